// File: rtl/venus_pkg.sv
// Shared definitions for the venus pipeline front end.
// Holds the fetch FSM state encoding, datapath width and the NOP word.
package venus_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_FULL  = 2'd2,
      S_DROP  = 2'd3
   } f_state_e;

endpackage

// File: rtl/f_skid_buf.sv
// One-entry {data,pc} holding register for the fetch stage.
// Ports: clk, rst (async, active-low), load_i, clear_i (clear wins),
// data_i/pc_i in, valid_o/data_o/pc_o out.
module f_skid_buf
   import venus_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] data_i,
   input  logic [XLEN-1:0] pc_i,
   output logic            valid_o,
   output logic [XLEN-1:0] data_o,
   output logic [XLEN-1:0] pc_o
);

   logic            valid_q;
   logic [XLEN-1:0] data_q;
   logic [XLEN-1:0] pc_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         pc_q    <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         pc_q    <= pc_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;

endmodule

// File: rtl/f_stage.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack imem port,
// presents {v_o,data_o,pc_o} downstream with stall_i, takes redirects.
// Ports: clk, rst, redir_i/redir_pc_i, imem_req_o/addr_o/ack_i/data_i,
// v_o, data_o, pc_o, stall_i.
module f_stage
   import venus_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] PC_STEP  = 32'd4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            redir_i,
   input  logic [XLEN-1:0] redir_pc_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_data_i,
   output logic            v_o,
   output logic [XLEN-1:0] data_o,
   output logic [XLEN-1:0] pc_o,
   input  logic            stall_i
);

   f_state_e        state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] dpc_q, dpc_d;
   logic            v_q, v_d;
   logic [XLEN-1:0] data_q, data_d;
   logic [XLEN-1:0] opc_q, opc_d;

   logic            sk_load, sk_clear, sk_v;
   logic [XLEN-1:0] sk_data, sk_pc;
   logic            req, adv;

   assign req = (state_q == S_FETCH) | (state_q == S_DROP);
   assign adv = ~stall_i | ~v_q;

   f_skid_buf u_skid (
      .clk     (clk),
      .rst     (rst),
      .load_i  (sk_load),
      .clear_i (sk_clear),
      .data_i  (imem_data_i),
      .pc_i    (pc_q),
      .valid_o (sk_v),
      .data_o  (sk_data),
      .pc_o    (sk_pc)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      dpc_d    = dpc_q;
      v_d      = v_q;
      data_d   = data_q;
      opc_d    = opc_q;
      sk_load  = 1'b0;
      sk_clear = 1'b0;
      if (redir_i) begin
         v_d      = 1'b0;
         sk_clear = 1'b1;
         pc_d     = redir_pc_i;
         // an unacked request must still complete at its old address
         if (req && !imem_ack_i) begin
            state_d = S_DROP;
            if (state_q == S_FETCH) dpc_d = pc_q;
         end else begin
            state_d = S_FETCH;
         end
      end else begin
         unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
               if (imem_ack_i) begin
                  pc_d = pc_q + PC_STEP;
                  if (adv) begin
                     v_d    = 1'b1;
                     data_d = imem_data_i;
                     opc_d  = pc_q;
                  end else begin
                     sk_load = 1'b1;
                     state_d = S_FULL;
                  end
               end else if (adv) begin
                  v_d = 1'b0;
               end
            end
            S_FULL: begin
               if (adv) begin
                  v_d      = sk_v;
                  data_d   = sk_data;
                  opc_d    = sk_pc;
                  sk_clear = 1'b1;
                  state_d  = S_FETCH;
               end
            end
            S_DROP: begin
               if (adv) v_d = 1'b0;
               if (imem_ack_i) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         dpc_q   <= RESET_PC;
         v_q     <= 1'b0;
         data_q  <= '0;
         opc_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         dpc_q   <= dpc_d;
         v_q     <= v_d;
         data_q  <= data_d;
         opc_q   <= opc_d;
      end
   end

   assign imem_req_o  = req;
   assign imem_addr_o = (state_q == S_DROP) ? dpc_q : pc_q;
   assign v_o         = v_q;
   assign data_o      = data_q;
   assign pc_o        = opc_q;

endmodule
